pipeline_control: RTL and testbench

- Central sequencer for the 5-stage LC-3b pipeline (IF, ID, EX, MEM, WB).
- Generates the load and flush strobes for the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and pc_load.
- Handles multi-cycle I-cache and D-cache handshakes, load-use bubbles and taken-branch squashes.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipeline_control_pkg.sv | 45 ++++
 rtl/handshake_latch.sv | 25 ++
 rtl/pipeline_control.sv | 117 +++++++++++
 tb/tb_pipeline_control.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_control_pkg.sv
// Shared types for the LC-3b pipeline sequencer: the bundled stage-register
// control word and its canonical settings.
package pipeline_control_pkg;

    typedef struct packed {
        logic pc_load;
        logic if_id_load;
        logic id_ex_load;
        logic ex_mem_load;
        logic mem_wb_load;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_STALL = '0;

    localparam pipe_ctrl_t CTRL_RESET = '{
        pc_load: 1'b0,
        if_id_load: 1'b1, id_ex_load: 1'b1, ex_mem_load: 1'b1, mem_wb_load: 1'b1,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1, mem_wb_flush: 1'b1
    };

    localparam pipe_ctrl_t CTRL_NORMAL = '{
        pc_load: 1'b1,
        if_id_load: 1'b1, id_ex_load: 1'b1, ex_mem_load: 1'b1, mem_wb_load: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0, mem_wb_flush: 1'b0
    };

    // Fetch and decode hold; a bubble is loaded into ID/EX.
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{
        pc_load: 1'b0,
        if_id_load: 1'b0, id_ex_load: 1'b1, ex_mem_load: 1'b1, mem_wb_load: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b0, mem_wb_flush: 1'b0
    };

    // Squash everything younger than the branch sitting in MEM.
    localparam pipe_ctrl_t CTRL_BRANCH = '{
        pc_load: 1'b1,
        if_id_load: 1'b1, id_ex_load: 1'b1, ex_mem_load: 1'b1, mem_wb_load: 1'b1,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1, mem_wb_flush: 1'b0
    };

endpackage

// File: rtl/handshake_latch.sv
// Sticky "response already seen" flag for a memory handshake that completed
// while the pipeline was still stalled on the other memory.
module handshake_latch (
    input  logic clk_i,
    input  logic rst_i,
    input  logic set_i,
    input  logic clr_i,
    output logic done_o
);

    logic done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
        end else if (clr_i) begin
            done_q <= 1'b0;
        end else if (set_i) begin
            done_q <= 1'b1;
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/pipeline_control.sv
// Central sequencer for the 5-stage LC-3b pipeline: stage-register load/flush
// strobes, I/D memory handshakes and saturating stall/flush counters.
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_sig,
    input  logic                 imem_resp,
    output logic                 imem_read,
    input  logic                 mem_stage_read,
    input  logic                 mem_stage_write,
    input  logic                 dmem_resp,
    output logic                 dmem_read,
    output logic                 dmem_write,
    input  logic                 load_use_hazard,
    input  logic                 br_taken,
    output logic                 pc_load,
    output logic                 if_id_load,
    output logic                 id_ex_load,
    output logic                 ex_mem_load,
    output logic                 mem_wb_load,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 mem_wb_flush,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    logic                 ifetch_done_q;
    logic                 dmem_done_q;
    logic                 if_ok;
    logic                 mem_op;
    logic                 mem_ok;
    logic                 advance;
    pipe_ctrl_t           ctrl;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic [CNT_WIDTH-1:0] flush_q, flush_d;

    assign if_ok   = imem_resp | ifetch_done_q;
    assign mem_op  = mem_stage_read | mem_stage_write;
    assign mem_ok  = ~mem_op | dmem_resp | dmem_done_q;
    assign advance = if_ok & mem_ok;

    handshake_latch u_ifetch_latch (
        .clk_i  (clk),
        .rst_i  (reset_sig),
        .set_i  (~advance & imem_resp),
        .clr_i  (advance),
        .done_o (ifetch_done_q)
    );

    handshake_latch u_dmem_latch (
        .clk_i  (clk),
        .rst_i  (reset_sig),
        .set_i  (~advance & dmem_resp),
        .clr_i  (advance),
        .done_o (dmem_done_q)
    );

    assign imem_read  = ~reset_sig & ~ifetch_done_q;
    assign dmem_read  = ~reset_sig & mem_stage_read  & ~dmem_done_q;
    assign dmem_write = ~reset_sig & mem_stage_write & ~dmem_done_q;

    // Branch outranks load-use: the dependent load's consumer is squashed anyway.
    always_comb begin
        ctrl = CTRL_STALL;
        if (reset_sig) begin
            ctrl = CTRL_RESET;
        end else if (!advance) begin
            ctrl = CTRL_STALL;
        end else if (br_taken) begin
            ctrl = CTRL_BRANCH;
        end else if (load_use_hazard) begin
            ctrl = CTRL_LOAD_USE;
        end else begin
            ctrl = CTRL_NORMAL;
        end
    end

    assign pc_load      = ctrl.pc_load;
    assign if_id_load   = ctrl.if_id_load;
    assign id_ex_load   = ctrl.id_ex_load;
    assign ex_mem_load  = ctrl.ex_mem_load;
    assign mem_wb_load  = ctrl.mem_wb_load;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!advance && stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end
        if (advance && br_taken && flush_q != '1) begin
            flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_sig) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: directed scenarios plus random
// stimulus against a cycle-level behavioural model of the sequencing rules.
module tb_pipeline_control;

    localparam int CW     = 16;
    localparam int CNTMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_sig, imem_resp, mem_stage_read, mem_stage_write, dmem_resp;
    logic load_use_hazard, br_taken;
    logic imem_read, dmem_read, dmem_write, pc_load;
    logic if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [CW-1:0] stall_count, flush_count;

    pipeline_control #(.CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .reset_sig       (reset_sig),
        .imem_resp       (imem_resp),
        .imem_read       (imem_read),
        .mem_stage_read  (mem_stage_read),
        .mem_stage_write (mem_stage_write),
        .dmem_resp       (dmem_resp),
        .dmem_read       (dmem_read),
        .dmem_write      (dmem_write),
        .load_use_hazard (load_use_hazard),
        .br_taken        (br_taken),
        .pc_load         (pc_load),
        .if_id_load      (if_id_load),
        .id_ex_load      (id_ex_load),
        .ex_mem_load     (ex_mem_load),
        .mem_wb_load     (mem_wb_load),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .mem_wb_flush    (mem_wb_flush),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: "response already seen" memory per side, and counts.
    bit m_ifetch_seen, m_dmem_seen;
    int m_stall, m_flush;

    logic [11:0] obs, exp_v;

    // Output vector: {imem_read, dmem_read, dmem_write, pc_load,
    //                 loads[if_id,id_ex,ex_mem,mem_wb], flushes[same order]}
    function automatic logic [11:0] get_obs();
        return {imem_read, dmem_read, dmem_write, pc_load,
                if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
    endfunction

    function automatic bit model_advance();
        bit fetch_ready, data_ready;
        fetch_ready = imem_resp || m_ifetch_seen;
        data_ready  = !(mem_stage_read || mem_stage_write) || dmem_resp || m_dmem_seen;
        return fetch_ready && data_ready;
    endfunction

    function automatic logic [11:0] model_outs();
        logic [2:0] req;
        if (reset_sig) return 12'b0000_1111_1111;
        req = {!m_ifetch_seen, mem_stage_read && !m_dmem_seen, mem_stage_write && !m_dmem_seen};
        if (!model_advance()) return {req, 9'b0};
        if (br_taken)         return {req, 1'b1, 4'b1111, 4'b1110};
        if (load_use_hazard)  return {req, 1'b0, 4'b0111, 4'b0100};
        return {req, 1'b1, 4'b1111, 4'b0000};
    endfunction

    task automatic model_commit();
        bit adv;
        adv = model_advance();
        if (reset_sig) begin
            m_ifetch_seen = 0; m_dmem_seen = 0; m_stall = 0; m_flush = 0;
        end else if (!adv) begin
            if (imem_resp) m_ifetch_seen = 1;
            if (dmem_resp) m_dmem_seen = 1;
            if (m_stall < CNTMAX) m_stall = m_stall + 1;
        end else begin
            m_ifetch_seen = 0; m_dmem_seen = 0;
            if (br_taken && m_flush < CNTMAX) m_flush = m_flush + 1;
        end
    endtask

    task automatic drive(input logic rst, input logic ir, input logic rd, input logic wr,
                         input logic dr, input logic lu, input logic br);
        @(negedge clk);
        reset_sig = rst; imem_resp = ir; mem_stage_read = rd; mem_stage_write = wr;
        dmem_resp = dr; load_use_hazard = lu; br_taken = br;
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 0, 0, 0, 0);
        obs = get_obs();
        n_vec++;
        if (obs !== 12'b0000_1111_1111) begin
            n_err++; $display("FAIL reset_outs: got %b want %b", obs, 12'b0000_1111_1111);
        end
        model_commit();
        for (int c = 0; c < 6; c++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            obs = get_obs(); exp_v = model_outs();
            n_vec++;
            if (obs !== exp_v || obs[7:0] !== 8'b1111_0000) begin
                n_err++; $display("FAIL post_reset_outs c%0d: got %b want %b", c, obs, exp_v);
            end
            n_vec++;
            if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
                n_err++; $display("FAIL post_reset_cnt: got %0d/%0d want 0/0", stall_count, flush_count);
            end
            model_commit();
        end
    endtask

    task automatic test_handshake();
        int stall_before;
        drive(1, 0, 0, 0, 0, 0, 0); model_commit();
        stall_before = m_stall;
        for (int c = 0; c <= 6; c++) begin
            drive(0, c == 2 || c == 6, c <= 5, 0, c == 5, 0, 0);
            obs = get_obs(); exp_v = model_outs();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++; $display("FAIL handshake_outs c%0d: got %b want %b", c, obs, exp_v);
            end
            if (c >= 3 && c <= 5) begin
                n_vec++;
                if (imem_read !== 1'b0) begin
                    n_err++; $display("FAIL handshake_imem_held c%0d: got %b want 0", c, imem_read);
                end
            end
            n_vec++;
            if (stall_count !== 16'(m_stall)) begin
                n_err++; $display("FAIL handshake_stall c%0d: got %0d want %0d", c, stall_count, m_stall);
            end
            model_commit();
        end
        n_vec++;
        if (m_stall - stall_before != 5) begin
            n_err++; $display("FAIL handshake_stall_delta: got %0d want 5", m_stall - stall_before);
        end
    endtask

    task automatic test_load_use();
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 0, 0, 0, c == 1, 0);
            obs = get_obs(); exp_v = model_outs();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++; $display("FAIL load_use_outs c%0d: got %b want %b", c, obs, exp_v);
            end
            model_commit();
        end
    endtask

    task automatic test_branch();
        int flush_before;
        drive(0, 1, 0, 0, 0, 1, 1);
        flush_before = m_flush;
        obs = get_obs(); exp_v = model_outs();
        n_vec++;
        if (obs !== exp_v || obs[8:0] !== 9'b1_1111_1110) begin
            n_err++; $display("FAIL branch_outs: got %b want %b", obs, exp_v);
        end
        model_commit();
        drive(0, 1, 0, 0, 0, 0, 0);
        n_vec++;
        if (flush_count !== 16'(flush_before + 1)) begin
            n_err++; $display("FAIL branch_flush_cnt: got %0d want %0d", flush_count, flush_before + 1);
        end
        model_commit();
    endtask

    task automatic test_reset_mid();
        // D-side answers while I-side is still pending: dmem flag sets.
        drive(0, 0, 1, 0, 1, 0, 0); model_commit();
        drive(0, 0, 1, 0, 0, 0, 0);
        n_vec++;
        if (dmem_read !== 1'b0 || imem_read !== 1'b1) begin
            n_err++; $display("FAIL mid_flag_set: got dr=%b ir=%b want 0/1", dmem_read, imem_read);
        end
        model_commit();
        drive(1, 0, 1, 0, 1, 0, 0);
        obs = get_obs();
        n_vec++;
        if (obs !== 12'b0000_1111_1111) begin
            n_err++; $display("FAIL mid_reset_outs: got %b want %b", obs, 12'b0000_1111_1111);
        end
        model_commit();
        drive(0, 0, 1, 0, 0, 0, 0);
        n_vec++;
        if (dmem_read !== 1'b1 || imem_read !== 1'b1 || stall_count !== 16'd0) begin
            n_err++; $display("FAIL mid_reset_clear: got dr=%b ir=%b st=%0d want 1/1/0",
                              dmem_read, imem_read, stall_count);
        end
        model_commit();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 5) == 0);
            obs = get_obs(); exp_v = model_outs();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++; $display("FAIL random_outs c%0d: got %b want %b", c, obs, exp_v);
            end
            n_vec++;
            if (stall_count !== 16'(m_stall) || flush_count !== 16'(m_flush)) begin
                n_err++; $display("FAIL random_cnt c%0d: got %0d/%0d want %0d/%0d",
                                  c, stall_count, flush_count, m_stall, m_flush);
            end
            model_commit();
        end
    endtask

    task automatic test_saturation();
        drive(1, 0, 0, 0, 0, 0, 0); model_commit();
        for (int c = 0; c < CNTMAX + 4; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0); model_commit();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (stall_count !== 16'hFFFF || stall_count !== 16'(m_stall)) begin
            n_err++; $display("FAIL stall_saturate: got %h want %h", stall_count, 16'(m_stall));
        end
        model_commit();
        drive(0, 1, 0, 0, 0, 0, 0); model_commit();
        drive(0, 1, 0, 0, 0, 0, 0);
        n_vec++;
        if (stall_count !== 16'hFFFF) begin
            n_err++; $display("FAIL stall_no_wrap: got %h want ffff", stall_count);
        end
        model_commit();
    endtask

    initial begin
        reset_sig = 1'b1; imem_resp = 1'b0; mem_stage_read = 1'b0; mem_stage_write = 1'b0;
        dmem_resp = 1'b0; load_use_hazard = 1'b0; br_taken = 1'b0;
        test_reset();
        test_handshake();
        test_load_use();
        test_branch();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
